bmp_stream_parser: RTL and testbench
====================================

// Module: bmp_stream_parser
// PURPOSE
//  Consumer end of the raw-BMP byte stream that the image benches load into an input FIFO.
//  Pops bytes from a first-word-fall-through FIFO, parses and checks the 54-byte BMP header,
//  packs 24-bit pixels, drops row padding, and pushes pixels into the pixel FIFO of the
//  filter pipeline (e.g. grayscale). Removes file parsing from testbenches and makes it synthesizable.
// PARAMETERS
//  MAX_WIDTH   1024  largest accepted image width in pixels; a larger header width -> error
//  MAX_HEIGHT  1024  largest accepted image height in pixels; a larger header height -> error
//  DIM_W       16    width of the dimension outputs and row/column counters
// PORTS
//  clock        in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-high
//  in_dout      in   8      head byte of the byte FIFO (valid when in_empty=0)
//  in_empty     in   1      byte FIFO empty
//  in_rd_en     out  1      pop the byte FIFO this cycle
//  out_din      out  24     pixel to the pixel FIFO: {file byte0, byte1, byte2}, byte0 in MSBs
//  out_full     in   1      pixel FIFO full
//  out_wr_en    out  1      push out_din this cycle
//  img_width    out  DIM_W  width from header bytes 18-21 (little-endian); valid once in PIX
//  img_height   out  DIM_W  height from header bytes 22-25; valid once in PIX
//  frame_done   out  1      one-cycle pulse after the last pixel of a frame is pushed
//  hdr_error    out  1      sticky; set by a header check failure, cleared only by reset
// BEHAVIOUR
//  - Reset (async): state=HDR; all counters, dimensions, byte regs = 0; frame_done=0, hdr_error=0.
//    in_rd_en and out_wr_en are gated with !reset, so they are 0 while reset is high.
//  - States: HDR -> CHK -> PIX <-> PAD -> DONE -> HDR; CHK -> ERR (terminal until reset).
//  - HDR: in_rd_en = !in_empty. Each pop stores the byte by hdr_cnt (0..53).
//    Bytes 0,1 = magic; 10-13 = data offset; 18-21 = width; 22-25 = height; 28-29 = bits per pixel.
//    After the pop with hdr_cnt==53 -> CHK.
//  - CHK (1 cycle, no pop): error unless magic==0x42,0x4D; offset==54; bpp==24;
//    1<=width<=MAX_WIDTH; height bit31==0; 1<=height<=MAX_HEIGHT.
//    Pass -> PIX and latch img_width/img_height. Fail -> ERR with hdr_error=1 and no further pops.
//  - PIX: byte_idx 0..2. Bytes 0 and 1 are popped when !in_empty and are held in registers.
//    Byte 2 is popped only when !in_empty && !out_full. In that cycle, combinationally:
//    out_wr_en=1 and out_din={b0,b1,in_dout}. Latency is zero cycles from the third byte.
//    in_empty or out_full stalls the block in place; no byte is lost and no write is duplicated.
//  - Column/row counters advance on each push. At end of row: if pad!=0 -> PAD, else next row.
//    pad = (4 - (3*width mod 4)) mod 4.
//  - PAD: pops and discards pad bytes when !in_empty, ignoring out_full. Then returns to PIX,
//    or goes to DONE if this was the last row.
//  - The last push of the frame goes to DONE. This happens after PAD when pad!=0.
//  - DONE (1 cycle): frame_done=1, no pop, counters cleared -> HDR. Back-to-back frames are supported.
//  - Rows are processed in file order (bottom-up); no reordering. Top-down (negative height) -> error.
//  - Reset mid-frame: the partial pixel is discarded and the next byte in the FIFO is treated as header byte 0.
// TESTING
//  1. Valid 720x540 header + 1166400 data bytes -> img_width=720, img_height=540, 388800 pushes,
//     first out_din={byte54,byte55,byte56}, one frame_done pulse, hdr_error=0.
//  2. 3x2 image (9 data bytes + 3 pad bytes per row) -> 6 pushes, pad bytes never appear on out_din,
//     total pops = 54+24 = 78.
//  3. out_full=1 for 10 cycles while byte_idx==2 -> in_rd_en=0 and out_wr_en=0 throughout;
//     the pixel is pushed exactly once after release.
//  4. in_empty toggling every other cycle during PIX -> pixel sequence identical to the no-stall run.
//  5. Header with bytes 0-1 = 0x42,0x41, or bpp=32, or width=2000 -> hdr_error=1 after CHK;
//     no pops afterwards; no pushes.
//  6. reset pulsed after 100 pixels, then a fresh 3x2 frame -> outputs 0 during reset;
//     6 correct pushes and one frame_done follow.

Source files
------------

// File: rtl/bmp_stream_parser_if.sv
// Byte-FIFO pop side and pixel-FIFO push side of the BMP stream parser.
// The parser is the master; the FIFOs (or a bench) sit on the slave modport.
interface bmp_stream_parser_if;
   logic [7:0]  in_dout;
   logic        in_empty;
   logic        in_rd_en;
   logic [23:0] out_din;
   logic        out_full;
   logic        out_wr_en;

   modport master (
      input  in_dout, in_empty, out_full,
      output in_rd_en, out_din, out_wr_en
   );

   modport slave (
      output in_dout, in_empty, out_full,
      input  in_rd_en, out_din, out_wr_en
   );
endinterface

// File: rtl/bmp_stream_parser.sv
// Parses a raw 24-bit BMP byte stream from a FWFT FIFO: checks the 54-byte header,
// packs pixels, drops row padding and pushes pixels into the pixel FIFO.
module bmp_stream_parser #(
   parameter int MAX_WIDTH  = 1024,
   parameter int MAX_HEIGHT = 1024,
   parameter int DIM_W      = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   bmp_stream_parser_if.master  bus,
   output logic [DIM_W-1:0]     img_width,
   output logic [DIM_W-1:0]     img_height,
   output logic                 frame_done,
   output logic                 hdr_error
);

   typedef enum logic [2:0] {S_HDR, S_CHK, S_PIX, S_PAD, S_DONE, S_ERR} state_t;

   state_t            state_q, state_d;
   logic [5:0]        hdr_cnt_q, hdr_cnt_d;
   logic [15:0]       magic_q, magic_d;
   logic [31:0]       offset_q, offset_d;
   logic [31:0]       width_q, width_d;
   logic [31:0]       height_q, height_d;
   logic [15:0]       bpp_q, bpp_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [7:0]        b0_q, b0_d, b1_q, b1_d;
   logic [DIM_W-1:0]  col_q, col_d, row_q, row_d;
   logic [1:0]        pad_cnt_q, pad_cnt_d;
   logic [DIM_W-1:0]  img_width_q, img_width_d, img_height_q, img_height_d;
   logic              frame_done_q, frame_done_d;
   logic              hdr_error_q, hdr_error_d;

   logic              rd_en, wr_en, hdr_ok, last_col, last_row;
   logic [1:0]        pad;

   // 3*w mod 4 == -w mod 4, so the pad byte count is simply w mod 4.
   assign pad      = img_width_q[1:0];
   assign last_col = (col_q == img_width_q - DIM_W'(1));
   assign last_row = (row_q == img_height_q - DIM_W'(1));

   assign hdr_ok = (magic_q == 16'h424D) && (offset_q == 32'd54) && (bpp_q == 16'd24) &&
                   (width_q != 32'd0) && (width_q <= 32'(MAX_WIDTH)) &&
                   !height_q[31] && (height_q != 32'd0) && (height_q <= 32'(MAX_HEIGHT));

   always_comb begin
      state_d      = state_q;
      hdr_cnt_d    = hdr_cnt_q;
      magic_d      = magic_q;
      offset_d     = offset_q;
      width_d      = width_q;
      height_d     = height_q;
      bpp_d        = bpp_q;
      byte_idx_d   = byte_idx_q;
      b0_d         = b0_q;
      b1_d         = b1_q;
      col_d        = col_q;
      row_d        = row_q;
      pad_cnt_d    = pad_cnt_q;
      img_width_d  = img_width_q;
      img_height_d = img_height_q;
      hdr_error_d  = hdr_error_q;
      rd_en        = 1'b0;
      wr_en        = 1'b0;

      unique case (state_q)
         S_HDR: begin
            rd_en = !bus.in_empty;
            if (rd_en) begin
               // Multi-byte fields arrive little-endian, so shift each one in from the top.
               if (hdr_cnt_q <= 6'd1)                        magic_d  = {magic_q[7:0], bus.in_dout};
               if (hdr_cnt_q >= 6'd10 && hdr_cnt_q <= 6'd13) offset_d = {bus.in_dout, offset_q[31:8]};
               if (hdr_cnt_q >= 6'd18 && hdr_cnt_q <= 6'd21) width_d  = {bus.in_dout, width_q[31:8]};
               if (hdr_cnt_q >= 6'd22 && hdr_cnt_q <= 6'd25) height_d = {bus.in_dout, height_q[31:8]};
               if (hdr_cnt_q >= 6'd28 && hdr_cnt_q <= 6'd29) bpp_d    = {bus.in_dout, bpp_q[15:8]};
               if (hdr_cnt_q == 6'd53) begin
                  hdr_cnt_d = '0;
                  state_d   = S_CHK;
               end else begin
                  hdr_cnt_d = hdr_cnt_q + 6'd1;
               end
            end
         end
         S_CHK: begin
            if (hdr_ok) begin
               img_width_d  = width_q[DIM_W-1:0];
               img_height_d = height_q[DIM_W-1:0];
               state_d      = S_PIX;
            end else begin
               hdr_error_d  = 1'b1;
               state_d      = S_ERR;
            end
         end
         S_PIX: begin
            if (byte_idx_q == 2'd2) begin
               rd_en = !bus.in_empty && !bus.out_full;
               wr_en = rd_en;
            end else begin
               rd_en = !bus.in_empty;
            end
            if (rd_en) begin
               unique case (byte_idx_q)
                  2'd0:    begin b0_d = bus.in_dout; byte_idx_d = 2'd1; end
                  2'd1:    begin b1_d = bus.in_dout; byte_idx_d = 2'd2; end
                  default: begin
                     byte_idx_d = 2'd0;
                     if (last_col) begin
                        col_d = '0;
                        if (pad != 2'd0) begin
                           pad_cnt_d = '0;
                           state_d   = S_PAD;
                        end else if (last_row) begin
                           state_d   = S_DONE;
                        end else begin
                           row_d     = row_q + DIM_W'(1);
                        end
                     end else begin
                        col_d = col_q + DIM_W'(1);
                     end
                  end
               endcase
            end
         end
         S_PAD: begin
            rd_en = !bus.in_empty;
            if (rd_en) begin
               if (pad_cnt_q == pad - 2'd1) begin
                  pad_cnt_d = '0;
                  if (last_row) begin
                     state_d = S_DONE;
                  end else begin
                     row_d   = row_q + DIM_W'(1);
                     state_d = S_PIX;
                  end
               end else begin
                  pad_cnt_d = pad_cnt_q + 2'd1;
               end
            end
         end
         S_DONE: begin
            hdr_cnt_d  = '0;
            byte_idx_d = '0;
            col_d      = '0;
            row_d      = '0;
            pad_cnt_d  = '0;
            state_d    = S_HDR;
         end
         default: state_d = S_ERR;
      endcase

      frame_done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_HDR;
         hdr_cnt_q    <= '0;
         magic_q      <= '0;
         offset_q     <= '0;
         width_q      <= '0;
         height_q     <= '0;
         bpp_q        <= '0;
         byte_idx_q   <= '0;
         b0_q         <= '0;
         b1_q         <= '0;
         col_q        <= '0;
         row_q        <= '0;
         pad_cnt_q    <= '0;
         img_width_q  <= '0;
         img_height_q <= '0;
         frame_done_q <= 1'b0;
         hdr_error_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         hdr_cnt_q    <= hdr_cnt_d;
         magic_q      <= magic_d;
         offset_q     <= offset_d;
         width_q      <= width_d;
         height_q     <= height_d;
         bpp_q        <= bpp_d;
         byte_idx_q   <= byte_idx_d;
         b0_q         <= b0_d;
         b1_q         <= b1_d;
         col_q        <= col_d;
         row_q        <= row_d;
         pad_cnt_q    <= pad_cnt_d;
         img_width_q  <= img_width_d;
         img_height_q <= img_height_d;
         frame_done_q <= frame_done_d;
         hdr_error_q  <= hdr_error_d;
      end
   end

   // Third byte goes straight through to the pixel FIFO in the cycle it is popped.
   assign bus.in_rd_en  = rd_en & ~reset;
   assign bus.out_wr_en = wr_en & ~reset;
   assign bus.out_din   = {b0_q, b1_q, bus.in_dout};

   assign img_width  = img_width_q;
   assign img_height = img_height_q;
   assign frame_done = frame_done_q;
   assign hdr_error  = hdr_error_q;

endmodule

// File: tb/tb_bmp_stream_parser.sv
// Bench for bmp_stream_parser: FIFO models on both sides, header vectors from a table,
// expected pixels computed from the file image with plain row-stride arithmetic.
module tb_bmp_stream_parser;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   bmp_stream_parser_if bus();
   logic [15:0] img_width, img_height;
   logic        frame_done, hdr_error;

   bmp_stream_parser #(.MAX_WIDTH(1024), .MAX_HEIGHT(1024), .DIM_W(16)) dut (
      .clock(clock), .reset(reset), .bus(bus),
      .img_width(img_width), .img_height(img_height),
      .frame_done(frame_done), .hdr_error(hdr_error)
   );

   typedef struct {
      logic [7:0]  m0, m1;
      logic [31:0] off, wid, hgt;
      logic [15:0] bpp;
      bit          exp_err;
      int          mode;   // 0 free-running, 1 random stalls, 2 in_empty every other cycle
   } vec_t;

   logic [7:0]  src[$];
   logic [23:0] got[$], exp_px[$];
   int n_cmp = 0, n_bad = 0;
   int pops = 0, exp_pops = 0, fd_cnt = 0, mode = 0;
   bit force_full = 1'b0, phase = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply_inputs();
      bit se, sf;
      se = 1'b0;
      sf = force_full;
      case (mode)
         1: begin se = ($urandom_range(0, 3) == 0); sf = sf | ($urandom_range(0, 3) == 0); end
         2: begin phase = !phase; se = phase; end
         default: ;
      endcase
      bus.in_empty = (src.size() == 0) || se;
      bus.in_dout  = (src.size() != 0) ? src[0] : 8'h00;
      bus.out_full = sf;
   endtask

   // Sample at negedge, let the DUT consume at posedge, drive new inputs just after.
   task automatic cycle();
      @(negedge clock);
      check("pop_while_empty", 64'(bus.in_rd_en & bus.in_empty), 0);
      check("push_while_full", 64'(bus.out_wr_en & bus.out_full), 0);
      if (bus.in_rd_en && !bus.in_empty) begin
         pops++;
         void'(src.pop_front());
      end
      if (bus.out_wr_en && !bus.out_full) got.push_back(bus.out_din);
      if (frame_done) fd_cnt++;
      @(posedge clock);
      #1;
      apply_inputs();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("rst_rd_en", 64'(bus.in_rd_en), 0);
         check("rst_wr_en", 64'(bus.out_wr_en), 0);
         check("rst_frame_done", 64'(frame_done), 0);
         check("rst_hdr_error", 64'(hdr_error), 0);
         check("rst_img_width", 64'(img_width), 0);
         @(posedge clock);
         #1;
      end
      reset = 1'b0;
      src.delete(); got.delete(); exp_px.delete();
      pops = 0; exp_pops = 0; fd_cnt = 0; force_full = 1'b0;
      apply_inputs();
   endtask

   task automatic load_frame(input vec_t v);
      logic [7:0] f[$];
      int w, h, stride, idx;
      for (int i = 0; i < 54; i++) f.push_back(8'h00);
      f[0] = v.m0;
      f[1] = v.m1;
      for (int k = 0; k < 4; k++) begin
         f[10 + k] = v.off[8*k +: 8];
         f[18 + k] = v.wid[8*k +: 8];
         f[22 + k] = v.hgt[8*k +: 8];
      end
      f[28] = v.bpp[7:0];
      f[29] = v.bpp[15:8];
      if (v.exp_err) begin
         for (int i = 0; i < 8; i++) f.push_back(8'($urandom));
         exp_pops += 54;
      end else begin
         w = int'(v.wid);
         h = int'(v.hgt);
         stride = ((3 * w + 3) / 4) * 4;
         for (int i = 0; i < stride * h; i++) f.push_back(8'($urandom));
         for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
               idx = 54 + r * stride + 3 * c;
               exp_px.push_back({f[idx], f[idx + 1], f[idx + 2]});
            end
         exp_pops += f.size();
      end
      foreach (f[i]) src.push_back(f[i]);
      apply_inputs();
   endtask

   task automatic run_until(input string name, input int fd_target, input int budget);
      int n = 0;
      while (fd_cnt < fd_target && n < budget) begin
         cycle();
         n++;
      end
      check({name, "_timeout"}, 64'(fd_cnt >= fd_target), 1);
      for (int i = 0; i < 3; i++) cycle();
   endtask

   task automatic check_frame(input string name, input int w, input int h, input int frames);
      int bad = 0;
      check({name, "_img_width"}, 64'(img_width), 64'(w));
      check({name, "_img_height"}, 64'(img_height), 64'(h));
      check({name, "_push_count"}, 64'(got.size()), 64'(exp_px.size()));
      for (int i = 0; i < got.size() && i < exp_px.size(); i++)
         if (got[i] !== exp_px[i]) bad++;
      check({name, "_pixels_wrong"}, 64'(bad), 0);
      check({name, "_pop_count"}, 64'(pops), 64'(exp_pops));
      check({name, "_frame_done_pulses"}, 64'(fd_cnt), 64'(frames));
      check({name, "_hdr_error"}, 64'(hdr_error), 0);
   endtask

   vec_t vecs[18];
   vec_t va, vb;

   initial begin
      bus.in_dout = 8'h00; bus.in_empty = 1'b1; bus.out_full = 1'b0;
      vecs[0]  = '{8'h42, 8'h4D, 32'd54, 32'd3,    32'd2,          16'd24, 1'b0, 0};
      vecs[1]  = '{8'h42, 8'h4D, 32'd54, 32'd1,    32'd1,          16'd24, 1'b0, 1};
      vecs[2]  = '{8'h42, 8'h4D, 32'd54, 32'd4,    32'd3,          16'd24, 1'b0, 1};
      vecs[3]  = '{8'h42, 8'h4D, 32'd54, 32'd5,    32'd2,          16'd24, 1'b0, 2};
      vecs[4]  = '{8'h42, 8'h4D, 32'd54, 32'd2,    32'd3,          16'd24, 1'b0, 1};
      vecs[5]  = '{8'h42, 8'h4D, 32'd54, 32'd7,    32'd5,          16'd24, 1'b0, 1};
      vecs[6]  = '{8'h42, 8'h4D, 32'd54, 32'd1024, 32'd1,          16'd24, 1'b0, 0};
      vecs[7]  = '{8'h42, 8'h4D, 32'd54, 32'd1,    32'd1024,       16'd24, 1'b0, 0};
      vecs[8]  = '{8'h42, 8'h41, 32'd54, 32'd3,    32'd2,          16'd24, 1'b1, 0};
      vecs[9]  = '{8'h42, 8'h4D, 32'd54, 32'd3,    32'd2,          16'd32, 1'b1, 1};
      vecs[10] = '{8'h42, 8'h4D, 32'd54, 32'd2000, 32'd2,          16'd24, 1'b1, 0};
      vecs[11] = '{8'h42, 8'h4D, 32'd54, 32'd0,    32'd2,          16'd24, 1'b1, 0};
      vecs[12] = '{8'h42, 8'h4D, 32'd54, 32'd3,    32'd0,          16'd24, 1'b1, 0};
      vecs[13] = '{8'h42, 8'h4D, 32'd54, 32'd3,    32'hFFFF_FFFE,  16'd24, 1'b1, 0};
      vecs[14] = '{8'h42, 8'h4D, 32'd56, 32'd3,    32'd2,          16'd24, 1'b1, 0};
      vecs[15] = '{8'h42, 8'h4D, 32'd54, 32'd3,    32'd1025,       16'd24, 1'b1, 0};
      vecs[16] = '{8'h42, 8'h4D, 32'd54, 32'd1025, 32'd2,          16'd24, 1'b1, 0};
      vecs[17] = '{8'h43, 8'h4D, 32'd54, 32'd3,    32'd2,          16'd24, 1'b1, 1};

      for (int i = 0; i < 18; i++) begin
         do_reset();
         mode = vecs[i].mode;
         load_frame(vecs[i]);
         if (vecs[i].exp_err) begin
            for (int c = 0; c < 150; c++) cycle();
            check($sformatf("v%0d_hdr_error", i), 64'(hdr_error), 1);
            check($sformatf("v%0d_pops", i), 64'(pops), 54);
            check($sformatf("v%0d_pushes", i), 64'(got.size()), 0);
            check($sformatf("v%0d_frame_done", i), 64'(fd_cnt), 0);
         end else begin
            run_until($sformatf("v%0d", i), 1, exp_pops * 3 + 200);
            check_frame($sformatf("v%0d", i), int'(vecs[i].wid), int'(vecs[i].hgt), 1);
         end
      end

      // Pixel FIFO held full while the third byte is waiting.
      do_reset();
      mode = 0;
      force_full = 1'b1;
      load_frame(vecs[0]);
      for (int n = 0; n < 500 && pops < 56; n++) cycle();
      check("full_reach_byte2", 64'(pops), 56);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check("full_hold_rd_en", 64'(bus.in_rd_en), 0);
         check("full_hold_wr_en", 64'(bus.out_wr_en), 0);
         @(posedge clock);
         #1;
      end
      force_full = 1'b0;
      apply_inputs();
      run_until("full_release", 1, 400);
      check_frame("full_release", 3, 2, 1);

      // Back-to-back frames without reset in between.
      do_reset();
      mode = 1;
      va = vecs[0];
      vb = vecs[3];
      load_frame(va);
      load_frame(vb);
      run_until("b2b", 2, exp_pops * 3 + 300);
      check_frame("b2b", 5, 2, 2);

      // Reset in the middle of a frame, then a fresh small frame.
      do_reset();
      mode = 1;
      va = '{8'h42, 8'h4D, 32'd54, 32'd12, 32'd10, 16'd24, 1'b0, 1};
      load_frame(va);
      for (int n = 0; n < 3000 && got.size() < 100; n++) cycle();
      check("midrst_reach_100px", 64'(got.size() >= 100), 1);
      do_reset();
      mode = 0;
      load_frame(vecs[0]);
      run_until("midrst_frame", 1, 400);
      check_frame("midrst_frame", 3, 2, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
